// File: rtl/synch_down_counter_if.sv
// synch_down_counter_if: control inputs and count/status outputs of the down counter
interface synch_down_counter_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             zero;
  logic             busy;
  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, tick, done, zero, busy
  );
  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, tick, done, zero, busy
  );
endinterface

// File: rtl/synch_down_counter.sv
// synch_down_counter: prescaled loadable down counter with pause, one-shot and auto-reload modes
module synch_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 8388608,
  parameter int PS_W     = 24
) (
  input logic clk,
  input logic reset,
  synch_down_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] count_q, count_nx, reload_q, reload_nx, eff;
  logic [PS_W-1:0] ps_q, ps_nx;
  logic tick_q, tick_nx, done_q, done_nx, step, last;
  assign eff  = bus.load ? bus.load_val : count_q;
  assign last = count_q <= WIDTH'(1);
  assign step = state == RUN && !bus.pause && ps_q == PS_MAX;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && eff != '0) state_nx = RUN;
      RUN:     if (bus.pause) state_nx = PAUSE;
               else if (step && last && !bus.auto_reload) state_nx = IDLE;
      default: if (bus.start && !bus.pause) state_nx = RUN;
    endcase
  end
  always_comb begin
    bus.busy  = state != IDLE;
    bus.count = count_q;
    bus.tick  = tick_q;
    bus.done  = done_q;
    bus.zero  = count_q == '0;
  end
  // A pause at the step phase holds the prescaler there so the pending step is never lost.
  always_comb begin
    count_nx  = count_q;
    reload_nx = reload_q;
    ps_nx     = ps_q;
    tick_nx   = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          count_nx  = bus.load_val;
          reload_nx = bus.load_val;
        end
        if (bus.start) begin
          ps_nx   = '0;
          done_nx = eff == '0;
        end
      end
      RUN: begin
        if (bus.pause) ps_nx = ps_q == PS_MAX ? ps_q : ps_q + 1'b1;
        else if (step) begin
          ps_nx    = '0;
          tick_nx  = 1'b1;
          done_nx  = last;
          count_nx = !last ? count_q - 1'b1 : bus.auto_reload ? reload_q : '0;
        end else ps_nx = ps_q + 1'b1;
      end
      default: if (bus.load) begin
        count_nx  = bus.load_val;
        reload_nx = bus.load_val;
        ps_nx     = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      ps_q     <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_nx;
      reload_q <= reload_nx;
      ps_q     <= ps_nx;
      tick_q   <= tick_nx;
      done_q   <= done_nx;
    end
endmodule

// File: tb/tb_synch_down_counter.sv
// tb_synch_down_counter: random and directed stimulus checked against a cycle-countdown model
module tb_synch_down_counter;
  localparam int P = 4;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit auto_r = 1'b0;
  synch_down_counter_if #(.WIDTH(4)) ifc();
  synch_down_counter #(.WIDTH(4), .PRESCALE(P), .PS_W(2)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  typedef struct {
    int mode;
    int count;
    int reload;
    int wait_c;
    bit tick;
    bit done;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t nxt(mdl_t c);
    mdl_t n;
    int eff;
    n = c;
    n.tick = 0;
    n.done = 0;
    eff = ifc.load ? int'(ifc.load_val) : c.count;
    if (reset) begin
      n.mode = 0; n.count = 0; n.reload = 0; n.wait_c = 0;
    end else if (c.mode == 0) begin
      if (ifc.load) begin n.count = int'(ifc.load_val); n.reload = int'(ifc.load_val); end
      if (ifc.start && eff != 0) begin n.mode = 1; n.wait_c = P - 1; end
      else if (ifc.start) n.done = 1;
    end else if (c.mode == 1) begin
      if (ifc.pause) begin
        n.mode = 2;
        if (c.wait_c > 0) n.wait_c = c.wait_c - 1;
      end else if (c.wait_c == 0) begin
        n.wait_c = P - 1;
        n.tick = 1;
        if (c.count > 1) n.count = c.count - 1;
        else begin
          n.done = 1;
          if (ifc.auto_reload) n.count = c.reload;
          else begin n.count = 0; n.mode = 0; end
        end
      end else n.wait_c = c.wait_c - 1;
    end else begin
      if (ifc.load) begin n.count = int'(ifc.load_val); n.reload = int'(ifc.load_val); n.wait_c = P - 1; end
      if (ifc.start && !ifc.pause) n.mode = 1;
    end
    return n;
  endfunction
  always @(posedge clk) m <= nxt(m);
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("model_count", int'(ifc.count), m.count);
      chk("model_tick", int'(ifc.tick), int'(m.tick));
      chk("model_done", int'(ifc.done), int'(m.done));
      chk("model_zero", int'(ifc.zero), int'(m.count == 0));
      chk("model_busy", int'(ifc.busy), int'(m.mode != 0));
    end
  task automatic set_in(bit r, bit l, int v, bit s, bit p, bit a);
    reset = r;
    ifc.load = l;
    ifc.load_val = 4'(v);
    ifc.start = s;
    ifc.pause = p;
    ifc.auto_reload = a;
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (ifc.busy && k < 200) begin cyc(1); k++; end
    chk("idle_timeout", int'(ifc.busy), 0);
  endtask
  task automatic clr();
    set_in(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    set_in(1, 1, 9, 1, 0, 0);
    cyc(2);
    chk("rst_count", int'(ifc.count), 0);
    chk("rst_zero", int'(ifc.zero), 1);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    clr();
    chk_en = 1'b1;
    set_in(0, 1, 5, 1, 0, 0); cyc(1); clr();
    chk("os_c1_count", int'(ifc.count), 5);
    chk("os_c1_busy", int'(ifc.busy), 1);
    cyc(3);
    chk("os_c4_count", int'(ifc.count), 5);
    cyc(1);
    chk("os_c5_count", int'(ifc.count), 4);
    chk("os_c5_tick", int'(ifc.tick), 1);
    cyc(15);
    chk("os_c20_count", int'(ifc.count), 1);
    chk("os_c20_done", int'(ifc.done), 0);
    cyc(1);
    chk("os_c21_count", int'(ifc.count), 0);
    chk("os_c21_done", int'(ifc.done), 1);
    chk("os_c21_tick", int'(ifc.tick), 1);
    chk("os_c21_busy", int'(ifc.busy), 0);
    set_in(0, 1, 3, 1, 0, 1); cyc(1); set_in(0, 0, 0, 0, 0, 1);
    chk("ar_c1_count", int'(ifc.count), 3);
    cyc(8);
    chk("ar_c9_count", int'(ifc.count), 1);
    cyc(4);
    chk("ar_c13_count", int'(ifc.count), 3);
    chk("ar_c13_done", int'(ifc.done), 1);
    chk("ar_c13_busy", int'(ifc.busy), 1);
    cyc(12);
    chk("ar_c25_count", int'(ifc.count), 3);
    chk("ar_c25_done", int'(ifc.done), 1);
    clr();
    wait_idle();
    set_in(0, 1, 4, 1, 0, 0); cyc(1); clr();
    cyc(5); set_in(0, 0, 0, 0, 1, 0);
    cyc(10);
    chk("pz_c16_count", int'(ifc.count), 3);
    chk("pz_c16_busy", int'(ifc.busy), 1);
    set_in(0, 0, 0, 1, 0, 0); cyc(1); clr();
    cyc(1);
    chk("pz_c18_count", int'(ifc.count), 3);
    cyc(1);
    chk("pz_c19_count", int'(ifc.count), 2);
    chk("pz_c19_tick", int'(ifc.tick), 1);
    cyc(4);
    chk("pz_c23_count", int'(ifc.count), 1);
    cyc(4);
    chk("pz_c27_count", int'(ifc.count), 0);
    chk("pz_c27_done", int'(ifc.done), 1);
    set_in(0, 1, 4, 1, 0, 0); cyc(1); clr();
    cyc(5); set_in(0, 0, 0, 0, 1, 0);
    cyc(2); set_in(0, 1, 15, 0, 1, 0);
    cyc(1);
    chk("pl_c9_count", int'(ifc.count), 15);
    set_in(0, 0, 0, 1, 0, 0); cyc(1); clr();
    cyc(3);
    chk("pl_c13_count", int'(ifc.count), 15);
    cyc(1);
    chk("pl_c14_count", int'(ifc.count), 14);
    set_in(1, 0, 0, 0, 0, 0); cyc(1); clr();
    set_in(0, 0, 0, 1, 0, 0); cyc(1); clr();
    chk("zs_done", int'(ifc.done), 1);
    chk("zs_busy", int'(ifc.busy), 0);
    cyc(1);
    chk("zs_done_after", int'(ifc.done), 0);
    set_in(0, 1, 6, 1, 0, 0); cyc(1); clr();
    cyc(1); set_in(0, 1, 2, 0, 0, 0);
    cyc(1); clr();
    chk("il_count", int'(ifc.count), 6);
    set_in(1, 0, 0, 0, 0, 0); cyc(1); clr();
    set_in(0, 1, 7, 1, 0, 0); cyc(1); clr();
    cyc(1); set_in(1, 0, 0, 0, 1, 0);
    cyc(1); clr();
    chk("rm_count", int'(ifc.count), 0);
    chk("rm_busy", int'(ifc.busy), 0);
    chk("rm_tick", int'(ifc.tick), 0);
    chk("rm_done", int'(ifc.done), 0);
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) auto_r = ~auto_r;
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, auto_r);
      cyc(1);
    end
    clr();
    cyc(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/synch_down_counter.md
# synch_down_counter

Loadable synchronous down counter (countdown timer), the downward companion to the board's synchronous up counter. Instead of running off a divided-down clock bit, it runs entirely on the system clock and uses an internal prescaler to generate a one-cycle count enable. It supports load, start, pause/resume, and one-shot or auto-reload modes, and reports terminal count with a done pulse. It sits between the board top level (keys/switches in) and the LEDs/HEX decoders (count out).

## Interface
- WIDTH, 4: counter width in bits.
- PRESCALE, 8388608: system-clock cycles per count step. Must be ≥ 1.
- PS_W, 24: prescaler register width. Must satisfy 2^PS_W ≥ PRESCALE.

- clk  in  1  system clock (CLOCK_50 at top level); all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load load_val into count and the reload register.
- load_val  in  WIDTH  value captured on load.
- start  in  1  begin counting (from IDLE) or resume (from PAUSE).
- pause  in  1  freeze counting.
- auto_reload  in  1  selects the terminal-count mode (1 = reload, 0 = one-shot); sampled on each terminal tick.
- count  out  WIDTH  current count, registered.
- tick  out  1  one-cycle pulse, high in the first cycle a decremented/reloaded count is visible.
- done  out  1  one-cycle pulse at terminal count.
- zero  out  1  level, high whenever count == 0 (combinational from count).
- busy  out  1  high in RUN and PAUSE.

## Operation
- Reset state (next cycle after reset is sampled high): state IDLE, count = 0, reload register = 0, prescaler = 0, tick = 0, done = 0, busy = 0, zero = 1. Reset overrides all other inputs.
- **States:** IDLE, RUN, PAUSE.
- **IDLE**
  - load: count ← load_val, reload ← load_val.
  - start with effective count ≠ 0: go to RUN, prescaler ← 0. The effective count is load_val if load is high in the same cycle, else the current count.
  - start with effective count == 0: done pulses the next cycle; stay in IDLE.
- **RUN**
  - Prescaler increments each cycle. When prescaler == PRESCALE−1 it wraps to 0 and a step occurs.
  - Step with count > 1: count ← count−1, tick pulses.
  - Step with count == 1 and auto_reload = 0: count ← 0, tick and done pulse, go to IDLE.
  - Step with count == 1 and auto_reload = 1: count ← reload, tick and done pulse, stay in RUN. Count never shows 0 in this mode.
  - pause: go to PAUSE. This takes priority over a step in the same cycle, so no step occurs.
  - load and start are ignored in RUN.
- **PAUSE**
  - Prescaler and count hold.
  - start with pause low: return to RUN, continuing from the held prescaler phase.
  - pause high wins over start.
  - load: count ← load_val, reload ← load_val, prescaler ← 0; stay in PAUSE.
- All arithmetic is unsigned modulo 2^WIDTH. Count never decrements below 0. No underflow wrap.

## Timing
- start sampled in cycle N → busy high from N+1, prescaler = 0 in N+1.
- First step is decided in cycle N+PRESCALE. The new count, tick, and done are visible in cycle N+PRESCALE+1.
- Later steps follow every PRESCALE cycles.
- A one-shot count of V takes V·PRESCALE cycles from start to done. busy falls in the same cycle done is high.
- Pausing for P cycles delays every remaining step by exactly P cycles.
- With PRESCALE = 1, count steps every cycle in RUN.
- tick and done are registered, single-cycle, and never high in consecutive cycles unless PRESCALE = 1.

## Test plan
All scenarios use WIDTH = 4, PRESCALE = 4.
- **Reset:** assert reset for 2 cycles, with load = 1, load_val = 9, start = 1 held throughout → count = 0, zero = 1, busy = 0, done = 0.
- **One-shot:** load + start with load_val = 5 in cycle 0 → count 5 (cycles 1–4), 4 (cycle 5), 3 (9), 2 (13), 1 (17), 0 (21). tick pulses in cycles 5, 9, 13, 17, 21; done pulses only in cycle 21; busy low from cycle 21.
- **Auto-reload:** auto_reload = 1, load_val = 3, start → count sequence 3, 2, 1, 3, 2, 1. done pulses in each cycle where count returns to 3; zero never asserts; busy stays high.
- **Pause/resume:** load_val = 4 + start in cycle 0. pause in cycle 6, held for 10 cycles, then start → count stays 3 while paused. Subsequent steps are visible at cycles 19, 23, 27 (original schedule + 10). load_val = 15 during PAUSE → count = 15, and the next step occurs 4 cycles after resume.
- **Zero start / ignored load:** start with count = 0 → done for one cycle, busy stays 0. During RUN with count = 6, load with load_val = 2 → count is unaffected.
- **Reset mid-run:** reset while count = 7 in RUN, with pause asserted → next cycle count = 0, IDLE, busy = 0, and no tick/done pulse.
